line_buffer_bridge: RTL and testbench
=====================================

Name: line_buffer_bridge

Overview:
- Sits directly downstream of the multicycle RV32I datapath/control and consumes its word-level memory requests (`mem_read`, `mem_write`, `mem_byte_enable`, address, wdata).
- Answers them from a single 256-bit line buffer.
- Misses are serviced over a 4-beat, 64-bit burst physical-memory interface; dirty lines are written back first.
- Provides the `mem_resp` handshake that the control FSM waits on in its fetch, load and store states.

Parameters:
- LINE_BITS, 256, line width in bits (fixed).
- BEAT_BITS, 64, burst beat width in bits.
- BEATS, 4, beats per line (LINE_BITS/BEAT_BITS).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_address  in  32  CPU byte address; word = addr[4:2], tag = addr[31:5]
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  4  write byte lanes
- mem_wdata  in  32  write data, already lane-aligned
- mem_rdata  out  32  read data, valid in the mem_resp cycle
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  line-aligned burst address (bits[4:0]=0)
- pmem_read  out  1  burst read request
- pmem_write  out  1  burst write request
- pmem_wdata  out  64  writeback beat data
- pmem_rdata  in  64  fill beat data
- pmem_resp  in  1  beat accepted/valid, one pulse per beat

Behaviour:
- Internal state:
  - valid, dirty, tag[26:0], line[255:0], beat counter cnt[1:0].
  - FSM states: IDLE, RESP, WRITEBACK, FILL.
- Reset: state=IDLE, valid=0, dirty=0, cnt=0. All outputs 0: mem_rdata, mem_resp, pmem_*.
- CPU rules:
  - The CPU holds request, address, byte enables and wdata stable until mem_resp.
  - Read and write asserted together is treated as a write.
- IDLE, no request: stay in IDLE.
- IDLE, request with hit (valid && tag==addr[31:5]):
  - Read: register line word addr[4:2] into mem_rdata, go to RESP.
  - Write: for each i with be[i]=1, overwrite byte (addr[4:2]*4+i) of the line; set dirty=1; go to RESP.
  - Hit latency: request seen in cycle N gives mem_resp=1 in cycle N+1.
- IDLE, request with miss: go to WRITEBACK if valid && dirty, else go to FILL. cnt=0.
- RESP:
  - mem_resp=1 for exactly one cycle; go to IDLE.
  - mem_rdata holds its value until the next read hit. Writes leave mem_rdata unchanged.
- WRITEBACK:
  - pmem_write=1, pmem_address={tag,5'b0}, pmem_wdata=line[64*cnt+63:64*cnt].
  - On pmem_resp: cnt++. On the 4th pmem_resp: dirty=0, cnt=0, go to FILL.
  - pmem_write stays high continuously across beats and drops the cycle after the last beat.
- FILL:
  - pmem_read=1, pmem_address={mem_address[31:5],5'b0}.
  - On pmem_resp: line[64*cnt+63:64*cnt]=pmem_rdata, cnt++.
  - On the 4th beat: valid=1, dirty=0, tag=mem_address[31:5], cnt=0, go to IDLE. The next cycle is then a hit, so miss latency is fill + 2 cycles.
- pmem_read and pmem_write are never asserted together. Neither is asserted in IDLE or RESP.
- mem_resp is never asserted outside RESP.
- cnt advances only on pmem_resp. Stalls of any length between beats are legal.
- cnt wraps 3→0 only at the burst end.
- Reset mid-operation (any state, including mid-burst):
  - Next cycle is IDLE with valid=0, dirty=0, cnt=0 and pmem_* deasserted.
  - The partial line is discarded.
  - The memory model is reset concurrently.
- Byte enable 4'b0000 on a write hit: data unchanged, dirty still set, mem_resp still issued.

Test Plan:
- Cold read: rst, then read 0x0000_0060, memory beats B0..B3 → pmem_read with pmem_address=0x60 for 4 beats, then mem_resp=1 with mem_rdata=B0[31:0]; exactly one mem_resp pulse.
- Read hit: read 0x0000_0064 after the previous case → mem_resp the cycle after the request, mem_rdata=B0[63:32], pmem_read/pmem_write stay 0.
- Store byte: write 0x0000_0066, be=4'b0100, wdata=0x00AB_0000 → hit, mem_resp next cycle. A following read of 0x64 returns B0[63:32] with bits[23:16]=0xAB.
- Dirty eviction: read 0x0000_1060 → 4-beat pmem_write to 0x60 (beat0 = modified B0), then 4-beat pmem_read from 0x1060, then mem_resp with the new word 0.
- Slow memory: pmem_resp delayed 5 cycles per beat → cnt advances only on resp, pmem_read held high throughout, data assembled in the correct beat order.
- Reset mid-fill: assert rst during FILL after 2 beats → next cycle all outputs 0, state IDLE. A re-read of the same address misses and refetches all 4 beats.

Source files
------------

// File: rtl/line_buffer_bridge.sv
// Single-line (256-bit) write-back buffer between the multicycle RV32I core's
// word port and a 4-beat, 64-bit burst memory. Misses evict dirty data before refilling.
module line_buffer_bridge #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64,
  parameter int BEATS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [BEAT_BITS-1:0] pmem_wdata,
  input  logic [BEAT_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic                 valid_r, valid_s;
  logic                 dirty_r, dirty_s;
  logic [26:0]          tag_r, tag_s;
  logic [LINE_BITS-1:0] line_r, line_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;

  logic [31:0]          rdata_s;
  logic                 resp_s;
  logic [31:0]          paddr_s;
  logic                 pread_s;
  logic                 pwrite_s;
  logic [BEAT_BITS-1:0] pwdata_s;

  logic                 req_s;
  logic                 hit_s;
  logic                 last_beat_s;
  logic [2:0]           word_s;
  logic                 unused_s;

  assign req_s       = mem_read | mem_write;
  assign hit_s       = valid_r && (tag_r == mem_address[31:5]);
  assign word_s      = mem_address[4:2];
  assign last_beat_s = (cnt_r == CNT_W'(BEATS - 1));
  assign unused_s    = ^mem_address[1:0];

  // Next-state, line update and next registered-output values
  always_comb begin
    state_s = state_r;
    valid_s = valid_r;
    dirty_s = dirty_r;
    tag_s   = tag_r;
    line_s  = line_r;
    cnt_s   = cnt_r;
    rdata_s = mem_rdata;

    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            if (mem_write) begin
              // Write wins over a simultaneous read; disabled lanes keep their old byte.
              for (int i = 0; i < 4; i++) begin
                line_s[{word_s, i[1:0], 3'b000} +: 8] = mem_byte_enable[i]
                  ? mem_wdata[{i[1:0], 3'b000} +: 8]
                  : line_r[{word_s, i[1:0], 3'b000} +: 8];
              end
              dirty_s = 1'b1;
            end else begin
              rdata_s = line_r[{word_s, 5'b00000} +: 32];
            end
            state_s = RESP;
          end else begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = (valid_r && dirty_r) ? WRITEBACK : FILL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          if (last_beat_s) begin
            dirty_s = 1'b0;
            cnt_s   = {CNT_W{1'b0}};
            state_s = FILL;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          line_s[{cnt_r, 6'b000000} +: BEAT_BITS] = pmem_rdata;
          if (last_beat_s) begin
            valid_s = 1'b1;
            dirty_s = 1'b0;
            tag_s   = mem_address[31:5];
            cnt_s   = {CNT_W{1'b0}};
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    resp_s   = (state_s == RESP);
    pread_s  = (state_s == FILL);
    pwrite_s = (state_s == WRITEBACK);
    case (state_s)
      WRITEBACK: paddr_s = {tag_r, 5'b00000};
      FILL:      paddr_s = {mem_address[31:5], 5'b00000};
      default:   paddr_s = 32'd0;
    endcase
    if (state_s == WRITEBACK) begin
      pwdata_s = line_r[{cnt_s, 6'b000000} +: BEAT_BITS];
    end else begin
      pwdata_s = {BEAT_BITS{1'b0}};
    end
  end

  // Line buffer state and FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      dirty_r <= 1'b0;
      tag_r   <= 27'd0;
      line_r  <= {LINE_BITS{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      valid_r <= valid_s;
      dirty_r <= dirty_s;
      tag_r   <= tag_s;
      line_r  <= line_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output registers, loaded from the values the next state will present
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata    <= 32'd0;
      mem_resp     <= 1'b0;
      pmem_address <= 32'd0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wdata   <= {BEAT_BITS{1'b0}};
    end else begin
      mem_rdata    <= rdata_s;
      mem_resp     <= resp_s;
      pmem_address <= paddr_s;
      pmem_read    <= pread_s;
      pmem_write   <= pwrite_s;
      pmem_wdata   <= pwdata_s;
    end
  end

endmodule

// File: tb/tb_line_buffer_bridge.sv
// Directed bench for line_buffer_bridge: a beat-level memory model answers bursts
// with a programmable stall while a linear sequence of CPU accesses is checked.
module tb_line_buffer_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  line_buffer_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [int];
  int          total = 0;
  int          bad = 0;
  int          rd_beats, wr_beats, read_held, both_hi, resp_cycle, tb_beat;
  logic [31:0] got_rdata, wb_addr, fill_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one CPU request and plays the memory side until mem_resp (or max_beats beats).
  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int dly, input int max_beats);
    int  stall;
    int  cyc;
    bit  done;
    int  idx;
    rd_beats = 0; wr_beats = 0; read_held = 0; resp_cycle = -1; tb_beat = 0;
    got_rdata = 32'd0; wb_addr = 32'd0; fill_addr = 32'd0;
    mem_address = addr; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd; pmem_resp = 1'b0;
    stall = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) both_hi++;
      if (pmem_read) read_held++;
      if (mem_resp) begin
        got_rdata  = mem_rdata;
        resp_cycle = cyc;
        done       = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (stall < dly) begin
          stall++;
        end else begin
          stall = 0;
          pmem_resp = 1'b1;
          idx = int'(pmem_address >> 3) + tb_beat;
          if (pmem_write) begin
            mem[idx] = pmem_wdata;
            wr_beats++;
            wb_addr = pmem_address;
          end else begin
            pmem_rdata = mem.exists(idx) ? mem[idx] : 64'd0;
            rd_beats++;
            fill_addr = pmem_address;
          end
          tb_beat = (tb_beat + 1) % 4;
          if (max_beats > 0 && (rd_beats + wr_beats) == max_beats) done = 1'b1;
        end
      end
    end
    chk("no_timeout", {63'd0, done}, 64'd1);
    if (max_beats == 0) begin
      @(negedge clk);
      chk("single_pulse", {63'd0, mem_resp}, 64'd0);
    end
  endtask

  initial begin
    mem[12]    = 64'h0123_4567_89AB_CDEF;
    mem[13]    = 64'h1111_2222_3333_4444;
    mem[14]    = 64'h5555_6666_7777_8888;
    mem[15]    = 64'h9999_AAAA_BBBB_CCCC;
    mem[32'h20C] = 64'hDEAD_BEEF_CAFE_F00D;
    mem[32'h20D] = 64'h0A0A_0A0A_0A0A_0A0A;
    mem[32'h20E] = 64'h0B0B_0B0B_0B0B_0B0B;
    mem[32'h20F] = 64'h0C0C_0C0C_0C0C_0C0C;
    mem[32'h40C] = 64'hA0A0_0001_A0A0_0000;
    mem[32'h40D] = 64'hB1B1_0003_B1B1_0002;
    mem[32'h40E] = 64'hC2C2_0005_C2C2_0004;
    mem[32'h40F] = 64'hD3D3_0007_D3D3_0006;
    mem[32'h60C] = 64'hE0E0_E0E0_1234_5678;
    mem[32'h60D] = 64'hE1E1_E1E1_E1E1_E1E1;
    mem[32'h60E] = 64'hE2E2_E2E2_E2E2_E2E2;
    mem[32'h60F] = 64'hE3E3_E3E3_E3E3_E3E3;
    both_hi = 0;

    rst = 1'b1; mem_address = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 4'd0; mem_wdata = 32'd0; pmem_rdata = 64'd0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {mem_resp, pmem_read, pmem_write, mem_rdata, pmem_address != 32'd0, pmem_wdata != 64'd0}, 64'd0);
    rst = 1'b0;

    // Cold read: 4-beat fill then resp at fill + 2.
    access(32'h0000_0060, 1'b1, 1'b0, 4'h0, 32'd0, 0, 0);
    chk("cold_rdata", {32'd0, got_rdata}, 64'h89AB_CDEF);
    chk("cold_fill_addr", {32'd0, fill_addr}, 64'h60);
    chk("cold_rd_beats", rd_beats, 64'd4);
    chk("cold_wr_beats", wr_beats, 64'd0);
    chk("cold_latency", resp_cycle, 64'd6);

    access(32'h0000_0064, 1'b1, 1'b0, 4'h0, 32'd0, 0, 0);
    chk("hit_rdata", {32'd0, got_rdata}, 64'h0123_4567);
    chk("hit_latency", resp_cycle, 64'd1);
    chk("hit_no_pmem", rd_beats + wr_beats + read_held, 64'd0);

    access(32'h0000_0066, 1'b0, 1'b1, 4'b0100, 32'h00AB_0000, 0, 0);
    chk("store_latency", resp_cycle, 64'd1);
    chk("store_keeps_rdata", {32'd0, got_rdata}, 64'h0123_4567);
    access(32'h0000_0064, 1'b1, 1'b0, 4'h0, 32'd0, 0, 0);
    chk("store_readback", {32'd0, got_rdata}, 64'h01AB_4567);

    // Zero byte enable: resp issued, data untouched.
    access(32'h0000_0060, 1'b1, 1'b1, 4'b0000, 32'hFFFF_FFFF, 0, 0);
    chk("be0_latency", resp_cycle, 64'd1);
    access(32'h0000_0060, 1'b1, 1'b0, 4'h0, 32'd0, 0, 0);
    chk("be0_readback", {32'd0, got_rdata}, 64'h89AB_CDEF);

    // Dirty eviction: writeback of the modified line, then refill.
    access(32'h0000_1060, 1'b1, 1'b0, 4'h0, 32'd0, 0, 0);
    chk("evict_wr_beats", wr_beats, 64'd4);
    chk("evict_wb_addr", {32'd0, wb_addr}, 64'h60);
    chk("evict_beat0", mem[12], 64'h01AB_4567_89AB_CDEF);
    chk("evict_beat3", mem[15], 64'h9999_AAAA_BBBB_CCCC);
    chk("evict_rd_beats", rd_beats, 64'd4);
    chk("evict_fill_addr", {32'd0, fill_addr}, 64'h1060);
    chk("evict_rdata", {32'd0, got_rdata}, 64'hCAFE_F00D);
    chk("evict_latency", resp_cycle, 64'd10);

    // Slow memory: 5 stall cycles before every beat.
    access(32'h0000_2060, 1'b1, 1'b0, 4'h0, 32'd0, 5, 0);
    chk("slow_rdata", {32'd0, got_rdata}, 64'hA0A0_0000);
    chk("slow_wr_beats", wr_beats, 64'd0);
    chk("slow_read_held", read_held, 64'd24);
    chk("slow_latency", resp_cycle, 64'd26);
    access(32'h0000_207C, 1'b1, 1'b0, 4'h0, 32'd0, 0, 0);
    chk("slow_word7", {32'd0, got_rdata}, 64'hD3D3_0007);
    access(32'h0000_2068, 1'b1, 1'b0, 4'h0, 32'd0, 0, 0);
    chk("slow_word2", {32'd0, got_rdata}, 64'hB1B1_0002);

    // Reset after two fill beats.
    access(32'h0000_3060, 1'b1, 1'b0, 4'h0, 32'd0, 0, 2);
    @(negedge clk);
    pmem_resp = 1'b0; mem_read = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {mem_resp, pmem_read, pmem_write, mem_rdata, pmem_address != 32'd0, pmem_wdata != 64'd0}, 64'd0);
    rst = 1'b0;
    access(32'h0000_3060, 1'b1, 1'b0, 4'h0, 32'd0, 0, 0);
    chk("refetch_rd_beats", rd_beats, 64'd4);
    chk("refetch_wr_beats", wr_beats, 64'd0);
    chk("refetch_latency", resp_cycle, 64'd6);
    chk("refetch_rdata", {32'd0, got_rdata}, 64'h1234_5678);

    chk("rd_wr_exclusive", both_hi, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
